// File: rtl/core_clk_pll_pkg.sv
// core_clk_pll_pkg
//   Shared types and widths for the core clock PLL reset controller.
//   pll_state_e : supervisor FSM states
//   RETRY_W     : width of the retry counter output
//   CNT_W       : shared counter width for the default cycle parameters
//   cnt_width() : counter width for an arbitrary parameter set
package core_clk_pll_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } pll_state_e;

    localparam int RETRY_W = 4;

    // One counter serves every timed state, so it is sized for the longest
    // interval. Each terminal compare is against N-1, so $clog2(N) bits suffice.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int CNT_W = cnt_width(16, 1024, 100000);

endpackage

// File: rtl/core_clk_pll_sync2.sv
// core_clk_pll_sync2
//   Two-flop synchroniser for a single asynchronous level.
//   clk : destination clock
//   rst : synchronous active-high reset, both flops clear to 0
//   d   : asynchronous input
//   q   : synchronised output, two clk edges behind d
module core_clk_pll_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/core_clk_pll_reset_ctrl.sv
// core_clk_pll_reset_ctrl
//   Supervises the core clock PLL from the board reference clock: pulses the
//   PLL reset, waits for lock with a timeout and bounded retries, requires the
//   lock to hold for a stable window before releasing the core reset, and
//   re-sequences the PLL if lock drops while running.
//   refclk     : 100 MHz reference clock (also the PLL input clock)
//   rst        : synchronous active-high reset
//   pll_locked : PLL lock indicator, asynchronous to refclk
//   pll_rst    : PLL reset drive
//   user_rst   : core reset, held until the lock is proven stable
//   ready      : high only while running
//   lock_lost  : single-cycle pulse when lock drops while running
//   fail       : sticky, retries exhausted; cleared only by rst
//   retry_cnt  : lock timeouts since the last time the core was released
module core_clk_pll_reset_ctrl
    import core_clk_pll_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int MAX_RETRIES         = 7
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               user_rst,
    output logic               ready,
    output logic               lock_lost,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);

    localparam logic [CW-1:0]      RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0]      STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0]      TO_LAST     = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    pll_state_e         state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [RETRY_W-1:0] retry_nxt;
    logic               locked_s;
    logic               pll_rst_nxt, user_rst_nxt, ready_nxt, lock_lost_nxt, fail_nxt;

    core_clk_pll_sync2 u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        unique case (state)
            PLL_RST: begin
                if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Lock seen on the timeout cycle wins over the retry.
                if (locked_s) begin
                    state_nxt = STABLE;
                end else if (cnt == TO_LAST) begin
                    if (retry_cnt == RETRY_MAX) begin
                        state_nxt = FAIL;
                    end else begin
                        retry_nxt = retry_cnt + RETRY_W'(1);
                        state_nxt = PLL_RST;
                    end
                end
            end
            STABLE: begin
                // A dropout restarts the lock wait with a full timeout but is
                // not a retry: the PLL did lock, it just was not clean yet.
                if (!locked_s)                state_nxt = WAIT_LOCK;
                else if (cnt == STABLE_LAST)  state_nxt = RUN;
            end
            RUN: begin
                if (!locked_s) state_nxt = PLL_RST;
            end
            FAIL: begin
                state_nxt = FAIL;
            end
            default: state_nxt = PLL_RST;
        endcase

        if (state_nxt == RUN) retry_nxt = '0;

        // Outputs decode the next state so they change on the same edge as the
        // state register rather than one cycle later.
        pll_rst_nxt   = (state_nxt == PLL_RST) || (state_nxt == FAIL);
        user_rst_nxt  = (state_nxt != RUN);
        ready_nxt     = (state_nxt == RUN);
        lock_lost_nxt = (state == RUN) && (state_nxt == PLL_RST);
        fail_nxt      = (state_nxt == FAIL);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= PLL_RST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            user_rst  <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= '0;
        end else begin
            state     <= state_nxt;
            // Counter wraps harmlessly in RUN/FAIL where it is never compared.
            cnt       <= (state_nxt != state) ? '0 : cnt + CW'(1);
            pll_rst   <= pll_rst_nxt;
            user_rst  <= user_rst_nxt;
            ready     <= ready_nxt;
            lock_lost <= lock_lost_nxt;
            fail      <= fail_nxt;
            retry_cnt <= retry_nxt;
        end
    end

endmodule
